seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 38 +++
 rtl/seq_alu_muldiv.sv | 80 ++++++++
 rtl/seq_alu.sv | 111 +++++++++++
 tb/tb_seq_alu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcodes, FSM state encoding and opcode-class helpers shared by seq_alu and its muldiv unit.
// Build option SEQ_ALU_MULDIV_EN adds the MUL/DIV states; otherwise only IDLE and DONE exist.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd3
  } state_t;
`endif

  function automatic logic is_mul(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiply / restoring divide (divu, remu), one bit per cycle.
// done is high in the WIDTH-th busy cycle with result already the final value; no backpressure.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;
  logic             rem_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] a_d, b_d, acc_d;
  logic [WIDTH:0]   trial;

  // mul: a_q multiplicand (shifts left), b_q multiplier (shifts right), acc_q product.
  // div: a_q dividend shifting out / quotient shifting in, b_q divisor, acc_q remainder.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    trial = {acc_q, a_q[WIDTH-1]};
    if (div_q) begin
      // A zero divisor always "fits", giving an all-ones quotient and remainder == dividend.
      if (trial >= {1'b0, b_q}) begin
        acc_d = trial[WIDTH-1:0] - b_q;
        a_d   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = trial[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end
  end

  assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign result = (div_q && !rem_q) ? a_d : acc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      div_q  <= is_div(op);
      rem_q  <= (op == OP_REMU);
      a_q    <= a;
      b_q    <= b;
      acc_q  <= '0;
    end else if (busy_q) begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready request and one-cycle out_valid; SEQ_ALU_MULDIV_EN adds mul/divu/remu.
// Latency 1 cycle (WIDTH+1 for mul/div); in_ready low while busy, requests then are ignored.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Z
);

  state_t           state_q, state_d;
  logic             accept;
  logic             res_ld;
  logic [WIDTH-1:0] alu_res, res_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (ALUControl)
      OP_ADD:  alu_res = a_in + b_in;
      OP_SUB:  alu_res = a_in - b_in;
      OP_AND:  alu_res = a_in & b_in;
      OP_OR:   alu_res = a_in | b_in;
      OP_XOR:  alu_res = a_in ^ b_in;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a_in) < $signed(b_in)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a_in < b_in};
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && (is_mul(ALUControl) || is_div(ALUControl))),
    .op     (ALUControl),
    .a      (a_in),
    .b      (b_in),
    .done   (md_done),
    .result (md_result)
  );
`endif

  always_comb begin
    state_d = state_q;
    res_ld  = 1'b0;
    res_d   = alu_res;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (is_mul(ALUControl)) begin
            state_d = MUL;
          end else if (is_div(ALUControl)) begin
            state_d = DIV;
          end else begin
            state_d = DONE;
            res_ld  = 1'b1;
          end
`else
          state_d = DONE;
          res_ld  = 1'b1;
`endif
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      MUL, DIV: begin
        if (md_done) begin
          state_d = DONE;
          res_ld  = 1'b1;
          res_d   = md_result;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Result and zero flag only change on a load, so both hold until the next result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResult <= '0;
      Z         <= 1'b1;
    end else if (res_ld) begin
      ALUResult <= res_d;
      Z         <= (res_d == '0);
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): scoreboard of expected result/flag/latency per request.
// Covers the SEQ_ALU_MULDIV_EN build when that macro is defined, the default build otherwise.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [3:0]  ALUControl = '0;
  logic        out_valid;
  logic [31:0] ALUResult;
  logic        Z;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .ALUResult  (ALUResult),
    .Z          (Z)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
`ifdef SEQ_ALU_MULDIV_EN
      4'b1000: return a * b;
      4'b1001: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1010: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op);
`ifdef SEQ_ALU_MULDIV_EN
    if (op == 4'b1000 || op == 4'b1001 || op == 4'b1010) return 33;
`endif
    return 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = model(op, a, b);
    e.z   = (e.res == 32'd0);
    e.lat = lat_of(op);
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the out_valid cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   cyc;
    int   early;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    ALUControl = op;
    a_in       = a;
    b_in       = b;
    push_exp(op, a, b);
    @(negedge clk);
    in_valid   = 1'b0;
    a_in       = $urandom;
    b_in       = $urandom;
    ALUControl = 4'($urandom_range(15));
    cyc   = 1;
    early = 0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) early++;
      @(negedge clk);
      cyc++;
    end
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " busy in_ready"}, 64'(early), 64'd0);
      check({tag, " latency"}, 64'(cyc), 64'(e.lat));
      check({tag, " result"}, 64'(ALUResult), 64'(e.res));
      check({tag, " Z"}, 64'(Z), 64'(e.z));
      @(negedge clk);
      check({tag, " pulse end"}, 64'(out_valid), 64'd0);
      check({tag, " held"}, 64'(ALUResult), 64'(e.res));
    end
  endtask

  initial begin
    exp_t e;
    int   pulses;

    repeat (3) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(ALUResult), 64'd0);
    check("reset Z", 64'(Z), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    run_op("add 7+5",     OP_ADD,  32'd7,          32'd5);
    run_op("sub 5-5",     OP_SUB,  32'd5,          32'd5);
    run_op("slt -1<1",    OP_SLT,  32'hFFFF_FFFF,  32'd1);
    run_op("sltu -1<1",   OP_SLTU, 32'hFFFF_FFFF,  32'd1);
    run_op("slt 1<-1",    OP_SLT,  32'd1,          32'hFFFF_FFFF);
    run_op("and",         OP_AND,  32'hF0F0_1234,  32'h0FF0_FF00);
    run_op("or",          OP_OR,   32'hF000_0001,  32'h0000_8000);
    run_op("xor",         OP_XOR,  32'hDEAD_BEEF,  32'hDEAD_BEEF);
    run_op("add wrap",    OP_ADD,  32'hFFFF_FFFF,  32'd1);
    run_op("sub wrap",    OP_SUB,  32'd0,          32'd1);
    run_op("default 1111", 4'b1111, 32'd9,         32'd9);
    run_op("default 0111", 4'b0111, 32'd3,         32'd4);

`ifdef SEQ_ALU_MULDIV_EN
    run_op("mul 10001^2", OP_MUL,  32'h0001_0001,  32'h0001_0001);
    run_op("mul big",     OP_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op("divu 100/7",  OP_DIVU, 32'd100,        32'd7);
    run_op("remu 100/7",  OP_REMU, 32'd100,        32'd7);
    run_op("divu 9/0",    OP_DIVU, 32'd9,          32'd0);
    run_op("remu 9/0",    OP_REMU, 32'd9,          32'd0);
    run_op("divu big",    OP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001);

    // Reset in the middle of a multiply: no pulse may follow for it.
    in_valid   = 1'b1;
    ALUControl = OP_MUL;
    a_in       = 32'd3;
    b_in       = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    pulses   = 0;
    for (int i = 1; i < 10; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort result", 64'(ALUResult), 64'd0);
    check("abort Z", 64'(Z), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("abort no pulse", 64'(pulses), 64'd0);
    run_op("add after abort", OP_ADD, 32'd7, 32'd5);
`else
    run_op("mul 3*4 off",  OP_MUL,  32'd3, 32'd4);
    run_op("divu off",     OP_DIVU, 32'd100, 32'd7);
    run_op("remu off",     OP_REMU, 32'd100, 32'd7);
`endif

    // A request held high while busy must be ignored, not queued.
    in_valid   = 1'b1;
    ALUControl = OP_ADD;
    a_in       = 32'd7;
    b_in       = 32'd5;
    push_exp(OP_ADD, 32'd7, 32'd5);
    @(negedge clk);
    ALUControl = OP_SUB;
    a_in       = 32'd1;
    b_in       = 32'd1;
    e = sb.pop_front();
    check("ignore first valid", 64'(out_valid), 64'd1);
    check("ignore first result", 64'(ALUResult), 64'(e.res));
    @(negedge clk);
    in_valid = 1'b0;
    check("ignore no second pulse", 64'(out_valid), 64'd0);
    check("ignore ready back", 64'(in_ready), 64'd1);
    check("ignore result held", 64'(ALUResult), 64'(e.res));
    @(negedge clk);
    check("ignore still idle", 64'(out_valid), 64'd0);
    check("ignore Z held", 64'(Z), 64'(e.z));

    // Reset must clear the result asynchronously, without waiting for a clock edge.
    reset = 1'b1;
    #1;
    check("async reset result", 64'(ALUResult), 64'd0);
    check("async reset Z", 64'(Z), 64'd1);
    check("async reset out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after reset in_ready", 64'(in_ready), 64'd1);
    run_op("add after reset", OP_ADD, 32'h8000_0000, 32'h8000_0000);
    run_op("and after reset", OP_AND, 32'h1234_5678, 32'hFFFF_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
